// File: rtl/array_9_port_ctrl.sv
// ============================================================================
// Module      : array_9_port_ctrl
// Description : SRAM port controller. It runs a zero-fill sweep after reset,
//               then serves read and write requests and returns reads through
//               a response FIFO. Optional macro: ARRAY_9_RW_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_9_port_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 13,
    parameter int DEPTH      = 512,
    parameter int RESP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              init_done,
    output logic              sram_r_en,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data
);

    localparam int c_ptr_w = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_W-1:0]  c_last_addr  = ADDR_W'(DEPTH - 1);
    localparam logic [c_cnt_w:0]   c_resp_depth = (c_cnt_w + 1)'(RESP_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(RESP_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_sweep;
    logic                r_pend;
    logic [DATA_W-1:0]   r_q_mem [RESP_DEPTH];
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_run;
    logic                w_init;
    logic                w_collide;
    logic                w_rd_block;
    logic [c_cnt_w:0]    w_occ;
    logic                w_rd_fire;
    logic                w_wr_fire;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_push_data;

    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign w_run     = (r_state == S_RUN);
    assign w_init    = (r_state == S_INIT);
    assign w_collide = wr_req_valid && (wr_req_addr == rd_req_addr);

    // Occupancy counts reads already issued to the SRAM so the queue can never overflow.
    assign w_occ = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_pend};

`ifdef ARRAY_9_RW_BYPASS_EN
    logic              r_byp_valid;
    logic [DATA_W-1:0] r_byp_data;

    assign w_rd_block  = 1'b0;
    assign w_push_data = r_byp_valid ? r_byp_data : sram_r_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_byp_valid <= 1'b0;
            r_byp_data  <= '0;
        end else begin
            r_byp_valid <= w_rd_fire && w_collide;
            r_byp_data  <= wr_req_data;
        end
    end
`else
    assign w_rd_block  = w_collide;
    assign w_push_data = sram_r_data;
`endif

    assign rd_req_ready = w_run && (w_occ < c_resp_depth) && !w_rd_block;
    assign wr_req_ready = w_run;
    assign init_done    = w_run;
    assign w_rd_fire    = rd_req_valid && rd_req_ready;
    assign w_wr_fire    = w_run && wr_req_valid;

    assign sram_r_en    = w_rd_fire;
    assign sram_r_addr  = w_rd_fire ? rd_req_addr : '0;
    assign sram_w_en    = w_init || w_wr_fire;
    assign sram_w_addr  = w_init ? r_sweep : (w_wr_fire ? wr_req_addr : '0);
    assign sram_w_data  = w_wr_fire ? wr_req_data : '0;

    assign w_push        = r_pend;
    assign w_pop         = (r_count != '0) && rd_resp_ready;
    assign rd_resp_valid = (r_count != '0);
    assign rd_resp_data  = rd_resp_valid ? r_q_mem[r_rptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_sweep <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_INIT;
                    r_sweep <= '0;
                end
                S_INIT: begin
                    if (r_sweep == c_last_addr) begin
                        r_state <= S_RUN;
                        r_sweep <= '0;
                    end else begin
                        r_sweep <= r_sweep + 1'b1;
                    end
                end
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // SRAM data for a read fired last cycle is valid now and is captured this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_pend <= w_rd_fire;
            if (w_push) r_wptr <= f_next(r_wptr);
            if (w_pop)  r_rptr <= f_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_q_mem[r_wptr] <= w_push_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_array_9_port_ctrl.sv
// Testbench for array_9_port_ctrl: SRAM model, reference memory and response scoreboard.
`default_nettype none

module tb_array_9_port_ctrl;

    localparam int AW = 9;
    localparam int DW = 13;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr = '0;
    logic          rd_resp_valid;
    logic          rd_resp_ready = 1'b1;
    logic [DW-1:0] rd_resp_data;
    logic          wr_req_valid = 1'b0;
    logic          wr_req_ready;
    logic [AW-1:0] wr_req_addr = '0;
    logic [DW-1:0] wr_req_data = '0;
    logic          init_done;
    logic          sram_r_en;
    logic [AW-1:0] sram_r_addr;
    logic [DW-1:0] sram_r_data = '0;
    logic          sram_w_en;
    logic [AW-1:0] sram_w_addr;
    logic [DW-1:0] sram_w_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] sram    [512];
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] exp_q   [$];

    always #5 clock = ~clock;

    array_9_port_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .init_done(init_done),
        .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
    );

    // Synchronous SRAM: read returns the pre-write contents on a same-cycle collision.
    always @(posedge clock) begin
        if (sram_w_en) sram[sram_w_addr] <= sram_w_data;
        if (sram_r_en) sram_r_data <= sram[sram_r_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expectations pushed on read fire, popped on response handshake.
    always @(negedge clock) begin
        if (reset_n) begin
            logic [DW-1:0] e;
            chk("sram_r_en_vs_fire", sram_r_en, rd_req_valid && rd_req_ready);
`ifndef ARRAY_9_RW_BYPASS_EN
            if (wr_req_valid && rd_req_valid && (wr_req_addr == rd_req_addr))
                chk("collision_blocks_read", rd_req_ready, 1'b0);
`endif
            if (rd_resp_valid && rd_resp_ready) begin
                chk("resp_has_expectation", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_data", rd_resp_data, e);
                end
            end
            if (rd_req_valid && rd_req_ready) begin
                if (wr_req_valid && wr_req_ready && (wr_req_addr == rd_req_addr))
                    exp_q.push_back(wr_req_data);
                else
                    exp_q.push_back(ref_mem[rd_req_addr]);
            end
            if (wr_req_valid && wr_req_ready) ref_mem[wr_req_addr] = wr_req_data;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic release_and_sweep(input string tag);
        int lat = -1;
        int wcnt = 0;
        int aerr = 0;
        int derr = 0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        exp_q.delete();
        reset_n = 1'b1;
        for (int k = 0; k <= 600 && lat < 0; k++) begin
            @(negedge clock);
            if (init_done) lat = k;
            else if (sram_w_en) begin
                if (sram_w_addr != 9'(wcnt)) aerr++;
                if (sram_w_data != '0) derr++;
                wcnt++;
            end
            next_cycle();
        end
        chk({tag, "_init_latency"}, lat, 513);
        chk({tag, "_wen_cycles"}, wcnt, 512);
        chk({tag, "_addr_seq_errs"}, aerr, 0);
        chk({tag, "_data_nonzero"}, derr, 0);
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        bit acc = 0;
        rd_req_valid = 1'b1;
        rd_req_addr  = a;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clock);
            if (rd_req_ready) acc = 1;
            next_cycle();
        end
        rd_req_valid = 1'b0;
        chk("read_accepted", acc, 1'b1);
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        @(negedge clock);
        chk("wr_ready", wr_req_ready, 1'b1);
        next_cycle();
        wr_req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [DW-1:0] d);
        bit got = 0;
        d = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (rd_resp_valid) begin
                got = 1;
                d = rd_resp_data;
            end
            next_cycle();
        end
        chk("resp_arrived", got, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int acc;
        int idx;
        int stalls;
        bit found;

        for (int i = 0; i < 512; i++) sram[i] = 13'($urandom) | 13'h1;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_rd_req_ready", rd_req_ready, 1'b0);
        chk("rst_wr_req_ready", wr_req_ready, 1'b0);
        chk("rst_rd_resp_valid", rd_resp_valid, 1'b0);
        chk("rst_rd_resp_data", rd_resp_data, 0);
        chk("rst_sram_w_en", sram_w_en, 1'b0);
        chk("rst_sram_r_en", sram_r_en, 1'b0);
        chk("rst_sram_w_addr", sram_w_addr, 0);

        release_and_sweep("sweep1");

        issue_read(9'h0AA);
        wait_resp(d);
        chk("read_0aa_zero", d, 0);

        // Write then read next cycle; response must appear exactly two cycles after fire.
        issue_write(9'h005, 13'h1ABC);
        rd_req_valid = 1'b1;
        rd_req_addr  = 9'h005;
        @(negedge clock);
        chk("lat_rd_ready", rd_req_ready, 1'b1);
        next_cycle();
        rd_req_valid = 1'b0;
        @(negedge clock);
        chk("lat_t1_resp_valid", rd_resp_valid, 1'b0);
        next_cycle();
        @(negedge clock);
        chk("lat_t2_resp_valid", rd_resp_valid, 1'b1);
        chk("lat_t2_resp_data", rd_resp_data, 13'h1ABC);
        next_cycle();

        // Backpressure: three reads fit, then ready drops until responses drain.
        for (int i = 0; i < 3; i++) issue_write(9'(9'h010 + i), 13'(13'h111 * (i + 1)));
        rd_resp_ready = 1'b0;
        rd_req_valid  = 1'b1;
        acc = 0;
        rd_req_addr = 9'h010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (rd_req_ready) acc++;
            next_cycle();
            rd_req_addr = 9'(9'h010 + acc);
        end
        @(negedge clock);
        chk("bp_ready_low", rd_req_ready, 1'b0);
        chk("bp_accepted", acc, 3);
        next_cycle();
        rd_req_valid  = 1'b0;
        rd_resp_ready = 1'b1;
        wait_resp(d);
        chk("bp_resp0", d, 13'h0111);
        wait_resp(d);
        chk("bp_resp1", d, 13'h0222);
        wait_resp(d);
        chk("bp_resp2", d, 13'h0333);
        @(negedge clock);
        chk("bp_drained", rd_resp_valid, 1'b0);
        next_cycle();

        // Same-cycle write and read of one address.
        wr_req_valid = 1'b1;
        wr_req_addr  = 9'h1FF;
        wr_req_data  = 13'h0F0F;
        rd_req_valid = 1'b1;
        rd_req_addr  = 9'h1FF;
        @(negedge clock);
`ifdef ARRAY_9_RW_BYPASS_EN
        chk("col_ready", rd_req_ready, 1'b1);
        next_cycle();
`else
        chk("col_ready", rd_req_ready, 1'b0);
        next_cycle();
        wr_req_valid = 1'b0;
        @(negedge clock);
        chk("col_ready_next", rd_req_ready, 1'b1);
        next_cycle();
`endif
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        wait_resp(d);
        chk("col_data", d, 13'h0F0F);

        // Reset with queued responses, then again in the middle of the sweep.
        rd_resp_ready = 1'b0;
        issue_read(9'h005);
        issue_read(9'h1FF);
        reset_n = 1'b0;
        #1;
        chk("midrd_resp_valid", rd_resp_valid, 1'b0);
        chk("midrd_init_done", init_done, 1'b0);
        rd_resp_ready = 1'b1;
        next_cycle();
        reset_n = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clock);
            if (sram_w_en && sram_w_addr == 9'd100) found = 1;
            else next_cycle();
        end
        chk("sweep_reached_100", found, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midsweep_w_en", sram_w_en, 1'b0);
        chk("midsweep_init_done", init_done, 1'b0);
        next_cycle();
        release_and_sweep("sweep2");

        // Read every address back-to-back; all must be zero and none may stall.
        rd_req_valid = 1'b1;
        idx = 0;
        stalls = 0;
        for (int k = 0; k < 700 && idx < 512; k++) begin
            rd_req_addr = 9'(idx);
            @(negedge clock);
            if (rd_req_ready) idx++;
            else stalls++;
            next_cycle();
        end
        rd_req_valid = 1'b0;
        chk("fullread_count", idx, 512);
        chk("fullread_stalls", stalls, 0);
        repeat (5) next_cycle();
        chk("fullread_drained", exp_q.size(), 0);

        // Random traffic over a small address window to provoke collisions and hazards.
        for (int c = 0; c < 10000; c++) begin
            rd_req_valid  = 1'($urandom_range(0, 1));
            rd_req_addr   = 9'($urandom_range(0, 15));
            wr_req_valid  = 1'($urandom_range(0, 1));
            wr_req_addr   = 9'($urandom_range(0, 15));
            wr_req_data   = 13'($urandom);
            rd_resp_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        rd_req_valid  = 1'b0;
        wr_req_valid  = 1'b0;
        rd_resp_ready = 1'b1;
        repeat (10) next_cycle();
        chk("random_drained", exp_q.size(), 0);
        chk("random_resp_valid_low", rd_resp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
